fc_bias_bram_rsp: RTL and testbench
===================================

# fc_bias_bram_rsp

Read responder for the fully-connected bias memory. It holds the bias table and serves the dual-port (A/B) reads issued by the FC layer controllers. It returns registered data plus a single `bias_bram_rd_vld` strobe after a fixed latency. A host-side load port fills the table before inference starts.

## Interface
Parameters:
- `DATA_W`, 16: bias word width.
- `ADDR_W`, 7: address width.
- `DEPTH`, 128: number of valid entries; must be ≤ 2^ADDR_W.
- `RD_LAT`, 2: cycles from a sampled enable to `bias_bram_rd_vld`; legal range 1..3.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load_en`  in  1  high while the host is loading the table.
- `load_we`  in  1  write strobe; honoured only in S_LOAD.
- `load_addr`  in  ADDR_W  write address.
- `load_data`  in  DATA_W  write data.
- `load_done`  out  1  sticky flag: table loaded.
- `bias_bram_ena` / `bias_bram_enb`  in  1  port A/B read enable.
- `bias_bram_addra` / `bias_bram_addrb`  in  ADDR_W  port A/B read address.
- `bias_bram_douta` / `bias_bram_doutb`  out  DATA_W  port A/B read data.
- `bias_bram_rd_vld`  out  1  read data valid.
- `rd_err`  out  1  one-cycle pulse on an illegal read.
- `rd_count`  out  8  number of valid responses since the last load; saturating.

## Operation
- States:
  - S_IDLE (reset state).
  - S_LOAD.
  - S_SERVE.
- Transitions:
  - S_IDLE → S_LOAD when `load_en`=1.
  - S_LOAD → S_SERVE on the first cycle `load_en`=0.
  - S_SERVE → S_LOAD when `load_en`=1.
  - S_IDLE stays put otherwise.
- S_LOAD:
  - `load_we`=1 writes `mem[load_addr]` <= `load_data`; a write with `load_addr` ≥ DEPTH is ignored.
  - `rd_count` clears to 0 on entry.
  - `load_done` clears on entry and sets on exit.
- Reads are accepted in S_IDLE and S_SERVE.
  - A read in S_IDLE returns the memory contents, which are undefined until the first load.
  - In S_LOAD, a sampled `ena`/`enb` is dropped: no `rd_vld`, and `rd_err` pulses.
- A port whose enable is sampled high captures `mem[addr]` into its data pipeline.
- A port whose enable is low holds its last output value.
- Address ≥ DEPTH: that port returns 0, and `rd_err` pulses at the same cycle as the corresponding `rd_vld`.
- `bias_bram_rd_vld` is the (`ena` | `enb`) sample delayed by RD_LAT cycles.
  - One strobe covers both ports.
  - Back-to-back enables give back-to-back strobes; there is no throughput limit and no backpressure.
- `rd_count` increments on each `rd_vld` cycle and saturates at 255.
- Both ports reading the same address return identical data in the same cycle.

## Timing
- Latency: enables/addresses sampled at edge N → `dout` and `rd_vld` valid after edge N+RD_LAT.
  - Data is held stable while `rd_vld`=1.
- Reset (`rst`=0, asynchronous):
  - State = S_IDLE.
  - `douta` = `doutb` = 0.
  - `rd_vld` = 0, `rd_err` = 0.
  - `rd_count` = 0, `load_done` = 0.
  - The pipeline is flushed.
  - Memory contents are not reset.
- Reset asserted mid-read: in-flight responses are discarded, with no late `rd_vld` after release.
- The first edge after `rst` rises samples inputs normally.
- `load_en` rising while reads are in flight: those reads still complete, and the `rd_vld` count includes them.
  - `rd_count` clears on S_LOAD entry first; completions landing after entry increment from 0.

## Structure
- Shared package `fc_pkg`: state encoding (S_IDLE/S_LOAD/S_SERVE), DATA_W/ADDR_W defaults, bias table DEPTH.
- Sub-module `rd_lat_pipe`: RD_LAT-deep shift register carrying {vld, err, douta, doutb}.
  - Asynchronous active-low clear.
  - Instantiated once.
- The top level holds the memory array, the state machine, the load logic and the counter.

## Test plan
- Reset, then load `mem[k]`=k+100 for k=0..127, drop `load_en` → `load_done`=1 one cycle later, state S_SERVE, `rd_count`=0.
- `ena`/`enb` high for 15 cycles with `addra`=11,13,…,39 and `addrb`=12,14,…,40 → 15 consecutive `rd_vld` strobes starting RD_LAT=2 cycles after the first enable.
  - First pair (111,112), last pair (139,140).
  - `rd_count`=15.
- DEPTH=100 build: read `addra`=105, `addrb`=5 → `douta`=0, `doutb`=105, `rd_err` pulse coincident with `rd_vld`.
- Read request while `load_en`=1 → no `rd_vld`, one `rd_err` pulse, memory unchanged.
- Assert `rst` one cycle after issuing a read → outputs 0 immediately; no `rd_vld` after release; memory still returns 111 at address 11.
- Issue 300 single-cycle reads → `rd_count` stops at 255; a new load clears it to 0.

Source files
------------

// File: rtl/fc_bias_bram_rsp_pkg.sv
// Shared definitions for the FC bias memory responder: state encoding,
// default geometry and the saturating response counter helper.
package fc_pkg;

  localparam int FC_DATA_W     = 16;
  localparam int FC_ADDR_W     = 7;
  localparam int FC_BIAS_DEPTH = 128;
  localparam int FC_RD_LAT     = 2;
  localparam int FC_CNT_W      = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SERVE = 2'd2
  } fc_state_e;

  function automatic logic [FC_CNT_W-1:0] sat_inc(input logic [FC_CNT_W-1:0] v);
    return (v == {FC_CNT_W{1'b1}}) ? v : v + FC_CNT_W'(1);
  endfunction

endpackage

// File: rtl/fc_bias_bram_rsp_if.sv
// Bus bundle between the FC layer controllers / host loader and the bias
// memory responder. The responder uses the slave view.
interface fc_bias_bram_rsp_if #(
  parameter int DATA_W = fc_pkg::FC_DATA_W,
  parameter int ADDR_W = fc_pkg::FC_ADDR_W
);
  import fc_pkg::*;

  logic                load_en;
  logic                load_we;
  logic [ADDR_W-1:0]   load_addr;
  logic [DATA_W-1:0]   load_data;
  logic                load_done;

  logic                bias_bram_ena;
  logic                bias_bram_enb;
  logic [ADDR_W-1:0]   bias_bram_addra;
  logic [ADDR_W-1:0]   bias_bram_addrb;
  logic [DATA_W-1:0]   bias_bram_douta;
  logic [DATA_W-1:0]   bias_bram_doutb;
  logic                bias_bram_rd_vld;
  logic                rd_err;
  logic [FC_CNT_W-1:0] rd_count;

  modport slave (
    input  load_en, load_we, load_addr, load_data,
    input  bias_bram_ena, bias_bram_enb, bias_bram_addra, bias_bram_addrb,
    output load_done,
    output bias_bram_douta, bias_bram_doutb, bias_bram_rd_vld, rd_err, rd_count
  );

  modport master (
    output load_en, load_we, load_addr, load_data,
    output bias_bram_ena, bias_bram_enb, bias_bram_addra, bias_bram_addrb,
    input  load_done,
    input  bias_bram_douta, bias_bram_doutb, bias_bram_rd_vld, rd_err, rd_count
  );

endinterface

// File: rtl/fc_bias_bram_rsp_rd_lat_pipe.sv
// Fixed-latency delay line for the read response {vld, err, douta, doutb}.
// Cleared asynchronously so no response survives a reset.
module rd_lat_pipe #(
  parameter int DATA_W = 16,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_i,
  input  logic              err_i,
  input  logic [DATA_W-1:0] douta_i,
  input  logic [DATA_W-1:0] doutb_i,
  output logic              vld_o,
  output logic              err_o,
  output logic [DATA_W-1:0] douta_o,
  output logic [DATA_W-1:0] doutb_o
);

  localparam int STAGE_W = 2 + 2 * DATA_W;

  logic [STAGE_W-1:0] stage_q [LAT];
  logic [STAGE_W-1:0] stage_d;

  assign stage_d = {vld_i, err_i, douta_i, doutb_i};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= stage_d;
      for (int i = 1; i < LAT; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign {vld_o, err_o, douta_o, doutb_o} = stage_q[LAT-1];

endmodule

// File: rtl/fc_bias_bram_rsp.sv
// Bias table for the FC layer: host load port, dual read ports with a
// registered read stage followed by an RD_LAT-deep response pipeline.
module fc_bias_bram_rsp
  import fc_pkg::*;
#(
  parameter int DATA_W = FC_DATA_W,
  parameter int ADDR_W = FC_ADDR_W,
  parameter int DEPTH  = FC_BIAS_DEPTH,
  parameter int RD_LAT = FC_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  fc_bias_bram_rsp_if.slave bus
);

  fc_state_e            state_q, state_d;
  logic                 load_done_q, load_done_d;
  logic [FC_CNT_W-1:0]  rd_count_q, rd_count_d;
  logic                 load_entry, load_exit;

  logic [DATA_W-1:0]    mem [DEPTH];
  logic                 wr_ok;

  logic                 rd_blocked;
  logic                 acc_a, acc_b;
  logic                 oob_a, oob_b;
  logic                 smp_vld_d, smp_err_d;
  logic                 smp_vld_q, smp_err_q;
  logic [DATA_W-1:0]    rdata_a_q, rdata_b_q;

  logic                 pipe_vld, pipe_err;
  logic [DATA_W-1:0]    pipe_da, pipe_db;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.load_en)  state_d = S_LOAD;
      S_LOAD:  if (!bus.load_en) state_d = S_SERVE;
      S_SERVE: if (bus.load_en)  state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase

    load_entry = (state_d == S_LOAD) && (state_q != S_LOAD);
    load_exit  = (state_q == S_LOAD) && (state_d == S_SERVE);

    load_done_d = load_done_q;
    if (load_entry) begin
      load_done_d = 1'b0;
    end else if (load_exit) begin
      load_done_d = 1'b1;
    end

    // Clear on entry wins, but a completion landing on that same edge still counts.
    rd_count_d = rd_count_q;
    if (load_entry) begin
      rd_count_d = pipe_vld ? FC_CNT_W'(1) : '0;
    end else if (pipe_vld) begin
      rd_count_d = sat_inc(rd_count_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      load_done_q <= 1'b0;
      rd_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      load_done_q <= load_done_d;
      rd_count_q  <= rd_count_d;
    end
  end

  assign wr_ok = (state_q == S_LOAD) && bus.load_we && (int'(bus.load_addr) < DEPTH);

  // Table contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  always_comb begin
    rd_blocked = (state_q == S_LOAD);
    acc_a      = bus.bias_bram_ena && !rd_blocked;
    acc_b      = bus.bias_bram_enb && !rd_blocked;
    oob_a      = int'(bus.bias_bram_addra) >= DEPTH;
    oob_b      = int'(bus.bias_bram_addrb) >= DEPTH;
    smp_vld_d  = acc_a || acc_b;
    smp_err_d  = (rd_blocked && (bus.bias_bram_ena || bus.bias_bram_enb))
               || (acc_a && oob_a) || (acc_b && oob_b);
  end

  // A port whose enable is low keeps its read register, so its output holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp_vld_q <= 1'b0;
      smp_err_q <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      smp_vld_q <= smp_vld_d;
      smp_err_q <= smp_err_d;
      if (acc_a) begin
        rdata_a_q <= oob_a ? '0 : mem[bus.bias_bram_addra];
      end
      if (acc_b) begin
        rdata_b_q <= oob_b ? '0 : mem[bus.bias_bram_addrb];
      end
    end
  end

  rd_lat_pipe #(
    .DATA_W (DATA_W),
    .LAT    (RD_LAT)
  ) u_rd_lat_pipe (
    .clk     (clk),
    .rst     (rst),
    .vld_i   (smp_vld_q),
    .err_i   (smp_err_q),
    .douta_i (rdata_a_q),
    .doutb_i (rdata_b_q),
    .vld_o   (pipe_vld),
    .err_o   (pipe_err),
    .douta_o (pipe_da),
    .doutb_o (pipe_db)
  );

  assign bus.bias_bram_douta  = pipe_da;
  assign bus.bias_bram_doutb  = pipe_db;
  assign bus.bias_bram_rd_vld = pipe_vld;
  assign bus.rd_err           = pipe_err;
  assign bus.rd_count         = rd_count_q;
  assign bus.load_done        = load_done_q;

endmodule

// File: tb/tb_fc_bias_bram_rsp.sv
// Scoreboard bench for fc_bias_bram_rsp: a full-depth instance and a
// DEPTH=100 instance share clock and reset.
module tb_fc_bias_bram_rsp;
  import fc_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 7;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fc_bias_bram_rsp_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
  fc_bias_bram_rsp_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

  fc_bias_bram_rsp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(128), .RD_LAT(LAT)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  fc_bias_bram_rsp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(100), .RD_LAT(LAT)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  typedef struct packed {
    logic          vld;
    logic          err;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } rsp_t;

  rsp_t q0[$];
  rsp_t q1[$];
  rsp_t e0, e1;
  int   vectors     = 0;
  int   miscompares = 0;
  int   strobes0    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push0(input logic v, input logic e, input int a, input int b);
    rsp_t r;
    r.vld = v; r.err = e; r.a = DW'(a); r.b = DW'(b);
    q0.push_back(r);
  endtask

  task automatic push1(input logic v, input logic e, input int a, input int b);
    rsp_t r;
    r.vld = v; r.err = e; r.a = DW'(a); r.b = DW'(b);
    q1.push_back(r);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitors: every vld or err strobe must match the head of its queue.
  always @(negedge clk) begin
    if (rst && (if0.bias_bram_rd_vld || if0.rd_err)) begin
      if (if0.bias_bram_rd_vld) strobes0++;
      if (q0.size() == 0) begin
        chk("dut0_unexpected_rsp", {30'd0, if0.bias_bram_rd_vld, if0.rd_err}, 32'd0);
      end else begin
        e0 = q0.pop_front();
        chk("dut0_vld", 32'(if0.bias_bram_rd_vld), 32'(e0.vld));
        chk("dut0_err", 32'(if0.rd_err), 32'(e0.err));
        if (e0.vld) begin
          chk("dut0_douta", 32'(if0.bias_bram_douta), 32'(e0.a));
          chk("dut0_doutb", 32'(if0.bias_bram_doutb), 32'(e0.b));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && (if1.bias_bram_rd_vld || if1.rd_err)) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_rsp", {30'd0, if1.bias_bram_rd_vld, if1.rd_err}, 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_vld", 32'(if1.bias_bram_rd_vld), 32'(e1.vld));
        chk("dut1_err", 32'(if1.rd_err), 32'(e1.err));
        if (e1.vld) begin
          chk("dut1_douta", 32'(if1.bias_bram_douta), 32'(e1.a));
          chk("dut1_doutb", 32'(if1.bias_bram_doutb), 32'(e1.b));
        end
      end
    end
  end

  initial begin
    if0.load_en = 0; if0.load_we = 0; if0.load_addr = '0; if0.load_data = '0;
    if0.bias_bram_ena = 0; if0.bias_bram_enb = 0;
    if0.bias_bram_addra = '0; if0.bias_bram_addrb = '0;
    if1.load_en = 0; if1.load_we = 0; if1.load_addr = '0; if1.load_data = '0;
    if1.bias_bram_ena = 0; if1.bias_bram_enb = 0;
    if1.bias_bram_addra = '0; if1.bias_bram_addrb = '0;

    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_douta",     32'(if0.bias_bram_douta), 32'd0);
    chk("rst_doutb",     32'(if0.bias_bram_doutb), 32'd0);
    chk("rst_rd_vld",    32'(if0.bias_bram_rd_vld), 32'd0);
    chk("rst_rd_err",    32'(if0.rd_err), 32'd0);
    chk("rst_rd_count",  32'(if0.rd_count), 32'd0);
    chk("rst_load_done", 32'(if0.load_done), 32'd0);
    chk("rst_state",     32'(dut0.state_q), 32'(S_IDLE));
    rst = 1'b1;

    // Load mem[k] = k+100 into both instances
    if0.load_en = 1; if1.load_en = 1;
    tick();
    for (int k = 0; k < 128; k++) begin
      if0.load_we = 1; if0.load_addr = AW'(k); if0.load_data = DW'(k + 100);
      if1.load_we = 1; if1.load_addr = AW'(k); if1.load_data = DW'(k + 100);
      tick();
    end
    if0.load_we = 0; if1.load_we = 0;
    chk("load_state_in_load", 32'(dut0.state_q), 32'(S_LOAD));
    chk("load_done_during",   32'(if0.load_done), 32'd0);
    if0.load_en = 0; if1.load_en = 0;
    tick();
    chk("load_done_after",    32'(if0.load_done), 32'd1);
    chk("load_done_after_d1", 32'(if1.load_done), 32'd1);
    chk("state_serve",        32'(dut0.state_q), 32'(S_SERVE));
    chk("count_after_load",   32'(if0.rd_count), 32'd0);

    // 15-cycle dual-port burst
    for (int i = 0; i < 15; i++) begin
      if (i == 2) chk("burst_vld_before_lat", 32'(if0.bias_bram_rd_vld), 32'd0);
      if (i == 3) chk("burst_vld_at_lat",     32'(if0.bias_bram_rd_vld), 32'd1);
      if0.bias_bram_ena = 1; if0.bias_bram_enb = 1;
      if0.bias_bram_addra = AW'(11 + 2 * i);
      if0.bias_bram_addrb = AW'(12 + 2 * i);
      push0(1'b1, 1'b0, 111 + 2 * i, 112 + 2 * i);
      tick();
    end
    if0.bias_bram_ena = 0; if0.bias_bram_enb = 0;
    repeat (LAT + 2) tick();
    chk("burst_strobes", 32'(strobes0), 32'd15);
    chk("burst_count",   32'(if0.rd_count), 32'd15);

    // DEPTH=100 instance: out-of-range port A, in-range port B
    if1.bias_bram_ena = 1; if1.bias_bram_enb = 1;
    if1.bias_bram_addra = AW'(105); if1.bias_bram_addrb = AW'(5);
    push1(1'b1, 1'b1, 0, 105);
    tick();
    if1.bias_bram_addra = AW'(99); if1.bias_bram_addrb = AW'(0);
    push1(1'b1, 1'b0, 199, 100);
    tick();
    if1.bias_bram_ena = 0; if1.bias_bram_enb = 0;
    repeat (LAT + 2) tick();
    chk("d1_count", 32'(if1.rd_count), 32'd2);

    // Read while loading is dropped with an error pulse
    if0.load_en = 1;
    tick();
    chk("count_clear_on_load", 32'(if0.rd_count), 32'd0);
    chk("load_done_cleared",   32'(if0.load_done), 32'd0);
    if0.bias_bram_ena = 1; if0.bias_bram_addra = AW'(11);
    push0(1'b0, 1'b1, 0, 0);
    tick();
    if0.bias_bram_ena = 0;
    repeat (LAT + 2) tick();
    if0.load_en = 0;
    tick();
    chk("drop_state_serve", 32'(dut0.state_q), 32'(S_SERVE));
    chk("drop_count",       32'(if0.rd_count), 32'd0);
    if0.bias_bram_ena = 1; if0.bias_bram_enb = 1;
    if0.bias_bram_addra = AW'(11); if0.bias_bram_addrb = AW'(127);
    push0(1'b1, 1'b0, 111, 227);
    tick();
    if0.bias_bram_ena = 0; if0.bias_bram_enb = 0;
    repeat (LAT + 2) tick();
    chk("post_drop_count", 32'(if0.rd_count), 32'd1);

    // Reset while a read is in flight
    if0.bias_bram_ena = 1; if0.bias_bram_enb = 1;
    if0.bias_bram_addra = AW'(13); if0.bias_bram_addrb = AW'(14);
    push0(1'b1, 1'b0, 113, 114);
    tick();
    if0.bias_bram_ena = 0; if0.bias_bram_enb = 0;
    tick();
    rst = 1'b0;
    q0.delete();
    #1;
    chk("midrst_douta",  32'(if0.bias_bram_douta), 32'd0);
    chk("midrst_doutb",  32'(if0.bias_bram_doutb), 32'd0);
    chk("midrst_vld",    32'(if0.bias_bram_rd_vld), 32'd0);
    chk("midrst_count",  32'(if0.rd_count), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    repeat (LAT + 3) tick();
    chk("midrst_state_idle", 32'(dut0.state_q), 32'(S_IDLE));
    if0.bias_bram_ena = 1; if0.bias_bram_enb = 1;
    if0.bias_bram_addra = AW'(11); if0.bias_bram_addrb = AW'(12);
    push0(1'b1, 1'b0, 111, 112);
    tick();
    if0.bias_bram_ena = 0; if0.bias_bram_enb = 0;
    repeat (LAT + 2) tick();

    // 300 reads saturate the counter; a new load clears it
    for (int k = 0; k < 300; k++) begin
      if0.bias_bram_ena = 1; if0.bias_bram_enb = 1;
      if0.bias_bram_addra = AW'(k % 128);
      if0.bias_bram_addrb = AW'((k * 3) % 128);
      push0(1'b1, 1'b0, (k % 128) + 100, ((k * 3) % 128) + 100);
      tick();
    end
    if0.bias_bram_ena = 0; if0.bias_bram_enb = 0;
    repeat (LAT + 2) tick();
    chk("sat_count", 32'(if0.rd_count), 32'd255);
    if0.load_en = 1;
    tick();
    chk("sat_count_cleared", 32'(if0.rd_count), 32'd0);
    if0.load_en = 0;
    tick();
    chk("reload_done", 32'(if0.load_done), 32'd1);

    repeat (LAT + 2) tick();
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
